// File: rtl/posit_pkg.sv
// Shared constants, stage payload types and special-value helpers for the
// posit encoder pipeline.
package posit_pkg;

   localparam int unsigned POSIT_N  = 8;
   localparam int unsigned POSIT_ES = 3;
   localparam int unsigned POSIT_RS = $clog2(POSIT_N);
   localparam int unsigned POSIT_KW = POSIT_RS + 2;

   typedef enum logic [2:0] {
      CLS_NORM,
      CLS_ZERO,
      CLS_NAR,
      CLS_MAX,
      CLS_MIN
   } cls_t;

   typedef struct packed {
      logic                    sign;
      cls_t                    cls;
      logic [POSIT_KW-1:0]     k;
      logic [POSIT_ES-1:0]     e;
      logic [2*POSIT_N-2:0]    frac;
   } s1_t;

   typedef struct packed {
      logic                    sign;
      cls_t                    cls;
      logic [POSIT_N-2:0]      body;
      logic                    g;
      logic                    s;
   } s2_t;

   function automatic logic [POSIT_N-1:0] nar(input int unsigned n);
      return POSIT_N'(1) << (n - 1);
   endfunction

   function automatic logic [POSIT_N-1:0] maxpos(input int unsigned n);
      return (POSIT_N'(1) << (n - 1)) - POSIT_N'(1);
   endfunction

   function automatic logic [POSIT_N-1:0] minpos(input int unsigned n);
      return POSIT_N'(n > 1);
   endfunction

endpackage

// File: rtl/posit_round.sv
// Round-to-nearest-even of the N-1 bit posit body, clamped to [minpos, maxpos],
// then sign application and special-value override.
module posit_round
   import posit_pkg::*;
#(
   parameter int unsigned N = POSIT_N
) (
   input  logic         sign,
   input  logic         is_nar,
   input  logic         is_zero,
   input  logic [N-2:0] body,
   input  logic         g,
   input  logic         s,
   output logic [N-1:0] result
);

   logic         inc;
   logic [N-1:0] sum;
   logic [N-1:0] mag;

   always_comb begin
      inc = g & (s | body[0]);
      sum = {1'b0, body} + N'(inc);
      mag = sum;
      // A carry into the sign position overflows past maxpos; a nonzero value must not collapse to zero.
      if (sum[N-1])
         mag = maxpos(N);
      else if (sum == '0)
         mag = minpos(N);

      result = sign ? -mag : mag;
      if (is_nar)
         result = nar(N);
      else if (is_zero)
         result = '0;
   end

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage posit encoder: classify/register, regime string build, round.
// Stages hand off with valid/ready; in_ready is combinational from out_ready.
module posit_encode_pipe
   import posit_pkg::*;
#(
   parameter int unsigned N  = POSIT_N,
   parameter int unsigned ES = POSIT_ES,
   parameter int unsigned RS = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              Sign,
   input  logic [ES+RS+1:0]  Total_EO,
   input  logic [2*N-1:0]    Mult_Mant_N,
   input  logic              inf,
   input  logic              zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      Result
);

   localparam int unsigned EW = ES + RS + 2;
   localparam int unsigned KW = RS + 2;
   localparam int unsigned W  = 3*N + ES;

   localparam logic signed [KW-1:0] K_HI = KW'(N - 2);
   localparam logic signed [KW-1:0] K_LO = -K_HI;
   localparam logic [N-1:0] MAXP = maxpos(N);
   localparam logic [N-1:0] MINP = minpos(N);

   logic s1_valid, s2_valid;
   logic s1_ready, s2_ready, s3_ready;
   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;
   logic [N-1:0] round_res;

   logic signed [KW-1:0] k_in;
   cls_t                 cls_in;
   logic                 unused_hidden;

   assign unused_hidden = Mult_Mant_N[2*N-1];

   assign s3_ready = !out_valid || out_ready;
   assign s2_ready = !s2_valid  || s3_ready;
   assign s1_ready = !s1_valid  || s2_ready;
   assign in_ready = s1_ready;

   // Stage 1: k is the arithmetic top slice of the total exponent, e the low ES bits.
   assign k_in = Total_EO[EW-1:ES];

   always_comb begin
      cls_in = CLS_NORM;
      if (inf)
         cls_in = CLS_NAR;
      else if (zero)
         cls_in = CLS_ZERO;
      else if (k_in >= K_HI)
         cls_in = CLS_MAX;
      else if (k_in <= K_LO)
         cls_in = CLS_MIN;

      s1_d.sign = Sign;
      s1_d.cls  = cls_in;
      s1_d.k    = k_in;
      s1_d.e    = Total_EO[ES-1:0];
      s1_d.frac = Mult_Mant_N[2*N-2:0];
   end

   // Stage 2: for k>=0 the ones-run is made by shifting zeros into the inverted
   // "10" template; for k<0 the zeros-run comes from shifting the leading 1 down.
   logic signed [KW-1:0] k1;
   logic [KW-1:0]        k_mag;
   logic [W-1:0]         x_pos, x_neg, str;

   always_comb begin
      k1    = s1_q.k;
      k_mag = k1[KW-1] ? -k1 : k1;
      x_pos = {2'b10, s1_q.e, s1_q.frac, {(N-1){1'b0}}};
      x_neg = {1'b1,  s1_q.e, s1_q.frac, {N{1'b0}}};
      str   = k1[KW-1] ? (x_neg >> k_mag) : ~((~x_pos) >> k_mag);

      s2_d.sign = s1_q.sign;
      s2_d.cls  = s1_q.cls;
      s2_d.body = str[W-1 -: N-1];
      s2_d.g    = str[W-N];
      s2_d.s    = |str[W-N-1:0];

      case (s1_q.cls)
         CLS_NORM: ;
         CLS_MAX: begin
            s2_d.body = MAXP[N-2:0];
            s2_d.g    = 1'b0;
            s2_d.s    = 1'b0;
         end
         CLS_MIN: begin
            s2_d.body = MINP[N-2:0];
            s2_d.g    = 1'b0;
            s2_d.s    = 1'b0;
         end
         default: begin
            s2_d.body = '0;
            s2_d.g    = 1'b0;
            s2_d.s    = 1'b0;
         end
      endcase
   end

   // Stage 3
   posit_round #(.N(N)) u_round (
      .sign    (s2_q.sign),
      .is_nar  (s2_q.cls == CLS_NAR),
      .is_zero (s2_q.cls == CLS_ZERO),
      .body    (s2_q.body),
      .g       (s2_q.g),
      .s       (s2_q.s),
      .result  (round_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         Result    <= '0;
      end else begin
         if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid)
               s1_q <= s1_d;
         end
         if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid)
               s2_q <= s2_d;
         end
         if (s3_ready) begin
            out_valid <= s2_valid;
            if (s2_valid)
               Result <= round_res;
         end
      end
   end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed-vector bench for posit_encode_pipe (N=8, ES=3) with an in-order
// scoreboard, latency, hold-under-stall and mid-stream reset checks.
module tb_posit_encode_pipe;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, sign, inf, zero, out_valid, out_ready;
   logic [7:0] total_eo;
   logic [15:0] mant;
   logic [7:0] result;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   posit_encode_pipe #(.N(8), .ES(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Sign        (sign),
      .Total_EO    (total_eo),
      .Mult_Mant_N (mant),
      .inf         (inf),
      .zero        (zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Result      (result)
   );

   typedef struct {
      logic [7:0]  res;
      int unsigned acc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          rx    = 0;
   bit          held  = 0;
   logic [7:0]  held_val;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic push(input logic s, input logic [7:0] eo, input logic [15:0] m,
                       input logic i, input logic z, input logic [7:0] want, input bit lat);
      bit done = 1'b0;
      sign = s; total_eo = eo; mant = m; inf = i; zero = z; in_valid = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         #1;
         if (in_ready) begin
            sb.push_back('{want, cyc + 1, lat});
            done = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end
      if (!done) chk("accept_timeout", 32'(done), 1);
   endtask

   task automatic idle();
      in_valid = 1'b0; inf = 1'b0; zero = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      exp_t e;
      int   rx0;
      rst_n = 1'b0; in_valid = 1'b0; sign = 1'b0; total_eo = '0; mant = '0;
      inf = 1'b0; zero = 1'b0; out_ready = 1'b1;

      fork
         forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
               held = 1'b0;
            end else begin
               if (out_valid && !out_ready) begin
                  if (held) chk("hold", result, held_val);
                  held = 1'b1;
                  held_val = result;
               end else begin
                  held = 1'b0;
               end
               if (out_valid && out_ready) begin
                  rx++;
                  if (sb.size() == 0) begin
                     chk("spurious", sb.size(), 1);
                  end else begin
                     e = sb.pop_front();
                     chk($sformatf("result#%0d", rx), result, e.res);
                     if (e.lat) chk($sformatf("latency#%0d", rx), cyc - e.acc + 1, 3);
                  end
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Directed vectors, back-to-back with no stalls
      push(1'b0, 8'd0,   16'h8000, 1'b0, 1'b0, 8'h40, 1'b1);
      push(1'b0, 8'd9,   16'hC000, 1'b0, 1'b0, 8'h63, 1'b1);
      push(1'b1, 8'd9,   16'hC000, 1'b0, 1'b0, 8'h9D, 1'b1);
      push(1'b0, 8'd0,   16'h9000, 1'b0, 1'b0, 8'h40, 1'b1);
      push(1'b0, 8'd0,   16'h9800, 1'b0, 1'b0, 8'h41, 1'b1);
      push(1'b0, 8'd48,  16'h8000, 1'b0, 1'b0, 8'h7F, 1'b1);
      push(1'b0, 8'd100, 16'h8000, 1'b0, 1'b0, 8'h7F, 1'b1);
      push(1'b0, 8'hD0,  16'h8000, 1'b0, 1'b0, 8'h01, 1'b1);
      push(1'b1, 8'h9C,  16'h8000, 1'b0, 1'b0, 8'hFF, 1'b1);
      push(1'b1, 8'd0,   16'h8000, 1'b1, 1'b1, 8'h80, 1'b1);
      push(1'b0, 8'd0,   16'h8000, 1'b0, 1'b1, 8'h00, 1'b1);
      push(1'b0, 8'd47,  16'h8000, 1'b0, 1'b0, 8'h7F, 1'b1);
      push(1'b0, 8'hD8,  16'h8000, 1'b0, 1'b0, 8'h02, 1'b1);
      push(1'b0, 8'hDF,  16'h8000, 1'b0, 1'b0, 8'h04, 1'b1);
      push(1'b1, 8'hF8,  16'h8000, 1'b0, 1'b0, 8'hE0, 1'b1);
      idle();
      drain("drain_directed");

      // Back-pressure: fill all three stages, stall, then resume
      rx0 = rx;
      out_ready = 1'b0;
      push(1'b0, 8'd0,  16'h8000, 1'b0, 1'b0, 8'h40, 1'b0);
      push(1'b0, 8'd9,  16'hC000, 1'b0, 1'b0, 8'h63, 1'b0);
      push(1'b1, 8'd9,  16'hC000, 1'b0, 1'b0, 8'h9D, 1'b0);
      #1;
      chk("bp_in_ready_full", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_head", result, 8'h40);
      sign = 1'b0; total_eo = 8'd0; mant = 16'h9800; in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         #1 chk("bp_stall_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      push(1'b0, 8'd0,   16'h9800, 1'b0, 1'b0, 8'h41, 1'b0);
      push(1'b0, 8'hD0,  16'h8000, 1'b0, 1'b0, 8'h01, 1'b0);
      push(1'b1, 8'hF8,  16'h8000, 1'b0, 1'b0, 8'hE0, 1'b0);
      idle();
      drain("drain_bp");
      repeat (6) @(negedge clk);
      chk("bp_count", rx - rx0, 6);

      // Reset with operands in flight
      out_ready = 1'b0;
      push(1'b0, 8'd9,  16'hC000, 1'b0, 1'b0, 8'h63, 1'b0);
      push(1'b0, 8'd48, 16'h8000, 1'b0, 1'b0, 8'h7F, 1'b0);
      push(1'b1, 8'd9,  16'hC000, 1'b0, 1'b0, 8'h9D, 1'b0);
      idle();
      chk("pre_rst_out_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_result", result, 0);
      sb.delete();
      rx0 = rx;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1 chk("post_rst_in_ready", in_ready, 1);
      repeat (10) @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_count", rx - rx0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/posit_encode_pipe.md
# posit_encode_pipe

Three-stage pipelined posit encoder directly downstream of the posit multiplier. It consumes the multiplier's sign, signed total exponent, normalised 2N-bit mantissa and inf/zero flags. It builds the regime/exponent/fraction bit string, rounds it to N bits (round-to-nearest-even), saturates and applies the sign. A valid/ready handshake lets the datapath absorb back-pressure from the register/writeback stage.

## Interface
- N, 8, posit width
- ES, 3, exponent field width
- RS, $clog2(N), regime count width; total exponent is ES+RS+2 bits signed
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream operand valid
- in_ready  out  1  encoder can accept this cycle
- Sign  in  1  result sign (Sign1^Sign2)
- Total_EO  in  ES+RS+2  signed total exponent, k = Total_EO>>>ES, e = Total_EO[ES-1:0]
- Mult_Mant_N  in  2N  normalised mantissa, hidden 1 at bit 2N-1, fraction in [2N-2:0]
- inf  in  1  NaR operand present
- zero  in  1  zero operand present
- out_valid  out  1  Result valid
- out_ready  in  1  downstream accepts
- Result  out  N  encoded posit

## Operation
- Special cases, in priority order: inf -> Result = 1 followed by N-1 zeros (NaR, 0x80 for N=8), regardless of zero/sign. zero -> all zeros. Otherwise encode normally.
- Stage 1 (S1): register inputs, compute k and e.
  - k >= N-2 -> saturate flag, body = maxpos (0111..1).
  - k <= -(N-2) -> saturate flag, body = minpos (000..01).
- Stage 2 (S2): build an unsigned body string.
  - k>=0: k+1 ones then a 0. k<0: -k zeros then a 1.
  - Then the ES exponent bits, then 2N-1 fraction bits.
  - Left-align via barrel shift. Top N-1 bits form the body. Next bit is guard g. OR of all remaining bits is sticky s.
- Stage 3 (S3), RNE rounding:
  - body += g & (s | body[0]).
  - If the increment carries into bit N-1, clamp to maxpos.
  - A nonzero operand never encodes to body 0; clamp to minpos.
  - Sign=1 -> Result = two's complement of {0,body}.
- Arithmetic: k and e come from an arithmetic shift/mask of Total_EO; no division. All shifts are unsigned, width at least 3N+ES.

## Timing
- Latency 3 cycles, in_valid&&in_ready to out_valid, with no stalls. Throughput 1/cycle.
- Each stage holds a valid bit.
  - Stage i advances when its downstream is empty or accepting.
  - in_ready = !s1_valid || S1 advancing. This is combinational from out_ready through the chain; no skid buffer.
- Result and out_valid are registered from S3. They hold stable while out_valid && !out_ready.
- Simultaneous in/out handshakes with a full pipeline: all stages shift, no bubble, no loss.
- Reset values: out_valid=0, Result=0, all stage valids 0. in_ready=1 once rst_n is high.
- Reset asserted mid-operation: all in-flight operands are discarded immediately (asynchronous); nothing is emitted afterwards.

## Structure
- Package posit_pkg:
  - functions nar(N), maxpos(N), minpos(N)
  - stage payload typedef (sign, special flags, k, e, mantissa); width from the package's N/ES constants
- One sub-module, posit_round: combinational RNE + maxpos clamp + sign application, instantiated in S3.
- Stages 1-2 are inline in posit_encode_pipe.

## Test plan
- N=8, ES=3, Sign=0, Total_EO=0, Mult_Mant_N=16'h8000 -> Result 0x40 three cycles after acceptance. Total_EO=9, Mant=16'hC000 -> 0x63. Same with Sign=1 -> 0x9D.
- RNE tie and above-tie: Total_EO=0, Mant=16'h9000 (g=1, s=0, lsb 0) -> 0x40. Mant=16'h9800 (s=1) -> 0x41.
- Saturation: Total_EO=48 (k=6) -> 0x7F. Total_EO=100 -> 0x7F. Total_EO=-48 -> 0x01. Total_EO=-100, Sign=1 -> 0xFF.
- Specials: inf=1 with zero=1 and Sign=1 -> 0x80. zero=1 alone -> 0x00.
- Back-pressure: stream 6 back-to-back operands while holding out_ready=0 for 4 cycles mid-stream.
  - in_ready drops once 3 operands are held.
  - Result stays stable while stalled.
  - All 6 results arrive in order; no duplicates.
- Reset mid-stream: assert rst_n=0 with 3 operands in flight.
  - out_valid=0 and Result=0 immediately.
  - After release, in_ready=1 and no stale results appear.
